rfid_pie_rx_core: RTL and testbench
===================================

// Module: rfid_pie_rx_core
// PURPOSE
// - Gen2-style reader-command receiver for the passive tag: samples PIE-coded demodin, extracts
//   delimiter/Tari/RTcal/TRcal, decodes data bits, classifies the command as a 9-bit one-hot type.
// - Includes a free-running 16-bit cycle counter with overflow flag (time base for stimulus/debug).
// - Feeds the tag command FSM and reply path; TX/FM0 modulation and memory access are out of scope.
// PARAMETERS
// - CNT_W      12  width of interval counters; intervals saturate at 2^CNT_W-1
// - MIN_DELIM   8  minimum low cycles for a valid delimiter
// PORTS
// - clk          in   1   sole clock; demodin sampled on posedge
// - reset        in   1   asynchronous, active-high; clears all state
// - demodin      in   1   demodulated envelope, idle high
// - comm_enable  in   1   0 = receiver held in IDLE, no commands reported
// - cnt_enable   in   1   increments count when 1
// - count        out  16  free-running cycle counter
// - overflow     out  1   1-cycle pulse on FFFF->0000 wrap
// - cmd_valid    out  1   1-cycle pulse at end of a command frame
// - cmd_type     out  9   one-hot: [0]QUERYREP [1]ACK [2]QUERY [3]QUERYADJ [4]SELECT [5]NACK
//                         [6]REQRN [7]READ [8]WRITE; all-0 = unrecognised; held until next cmd_valid
// - bit_count    out  8   data bits in last frame (saturates 255)
// - rx_word      out  32  first 32 data bits, first bit in MSB position once 32 received, left-aligned
// - rtcal, trcal out  CNT_W  last measured calibration intervals (trcal=0 if frame had none)
// - debug_out    out  1   1 while FSM in DATA
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; count 0.
// - Counter: if cnt_enable, count<=count+1 mod 2^16; overflow<=1 exactly the cycle count goes 0.
// - Intervals measured rising edge to rising edge of demodin (registered samples; edge = prev!=cur).
// - FSM: IDLE -(falling edge)-> DELIM: count low cycles; rising edge with low>=MIN_DELIM -> TARI,
//   else IDLE. TARI: interval to next rising edge = data-0 length (stored, informational) -> RTCAL.
//   RTCAL: next interval stored as rtcal -> CAL2. CAL2: next interval I: if I>rtcal store trcal,
//   go DATA; else I is first data bit (frame-sync), trcal=0, decode it, go DATA.
// - DATA: each interval I -> bit = (I >= rtcal>>1); shift into rx_word (stop after 32), bit_count++.
// - Frame end: in DATA/CAL2, demodin held high for rtcal+1 cycles since last rising edge ->
//   next cycle cmd_valid=1, cmd_type/bit_count/rx_word/rtcal/trcal update, FSM IDLE.
// - Classification on leading bits and bit_count: 00 len4 QUERYREP; 01 len18 ACK; 1000 len22 QUERY;
//   1001 len9 QUERYADJ; 1010 len>=44 SELECT; 11000000 len8 NACK; 11000001 len40 REQRN;
//   11000010 len>=57 READ; 11000011 len>=58 WRITE; else 0.
// - Errors: any interval or low time reaching saturation, or low time >= rtcal in DATA -> IDLE
//   silently (no cmd_valid). Falling edge in IDLE always restarts at DELIM.
// - comm_enable=0: FSM forced IDLE next cycle; outputs hold previous values; counter unaffected.
// - Reset mid-frame: immediate clear, no cmd_valid.
// TESTING
// - Reset release, cnt_enable=1, 2000 cycles -> count=2000 after 2000 edges, overflow never set.
// - Preload via 65535 enabled cycles -> next cycle count=0, overflow pulses exactly once.
// - Delim 24 low, data-0 24H+24L, RTcal 96H+24L(120), TRcal 120H+24L(144), Query 1000+18 bits
//   (data-1=48H+24L), trailing high -> cmd_type=9'b000000100, bit_count=22, rtcal=120, trcal=144.
// - Same timing, no TRcal, bits 1001_0_11_0_1 -> cmd_type=9'b000001000, bit_count=9, trcal=0.
// - Delimiter only 4 low cycles -> no cmd_valid; FSM back to IDLE.
// - comm_enable=0 during a valid Query -> no cmd_valid; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/rfid_pie_rx_core.sv
// rfid_pie_rx_core: PIE command receiver for a Gen2-style tag plus a free-running cycle counter.
// Measures delimiter/Tari/RTcal/TRcal, decodes data bits and classifies the frame as a one-hot type.
module rfid_pie_rx_core #(
    parameter int CNT_W     = 12,
    parameter int MIN_DELIM = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_demodin,
    input  logic             i_comm_enable,
    input  logic             i_cnt_enable,
    output logic [15:0]      o_count,
    output logic             o_overflow,
    output logic             o_cmd_valid,
    output logic [8:0]       o_cmd_type,
    output logic [7:0]       o_bit_count,
    output logic [31:0]      o_rx_word,
    output logic [CNT_W-1:0] o_rtcal,
    output logic [CNT_W-1:0] o_trcal,
    output logic             o_debug_out
);
    typedef enum logic [2:0] {S_IDLE, S_DELIM, S_TARI, S_RTCAL, S_CAL2, S_DATA} state_t;
    localparam logic [CNT_W-1:0] SAT = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELIM_MIN = CNT_W'(MIN_DELIM);
    state_t            r_state;
    logic              r_din, r_prev;
    logic [CNT_W-1:0]  r_ivl, r_low, r_cal, r_tr;
    logic [7:0]        r_bits;
    logic [31:0]       r_word;
    logic [15:0]       r_count;
    logic              r_overflow, r_cmd_valid;
    logic [8:0]        r_cmd_type;
    logic [7:0]        r_bit_count;
    logic [31:0]       r_rx_word;
    logic [CNT_W-1:0]  r_rtcal, r_trcal;
    logic              w_rise, w_fall, w_sat, w_bit, w_end;
    logic [7:0]        w_h;
    logic [8:0]        w_type;
    assign w_rise = r_din & ~r_prev;
    assign w_fall = ~r_din & r_prev;
    assign w_sat  = (r_ivl == SAT) || (r_low == SAT);
    assign w_bit  = r_ivl >= (r_cal >> 1);
    // the rising-edge cycle carries the just-measured interval, so it never counts as trailing high
    assign w_end  = r_din && !w_rise && (r_ivl > r_cal);
    assign w_h    = r_word[31:24];
    assign w_type = {
        w_h == 8'hC3 && r_bits >= 8'd58,
        w_h == 8'hC2 && r_bits >= 8'd57,
        w_h == 8'hC1 && r_bits == 8'd40,
        w_h == 8'hC0 && r_bits == 8'd8,
        w_h[7:4] == 4'b1010 && r_bits >= 8'd44,
        w_h[7:4] == 4'b1001 && r_bits == 8'd9,
        w_h[7:4] == 4'b1000 && r_bits == 8'd22,
        w_h[7:6] == 2'b01 && r_bits == 8'd18,
        w_h[7:6] == 2'b00 && r_bits == 8'd4
    };
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_din       <= 1'b0;
            r_prev      <= 1'b0;
            r_ivl       <= '0;
            r_low       <= '0;
            r_cal       <= '0;
            r_tr        <= '0;
            r_bits      <= '0;
            r_word      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= '0;
            r_bit_count <= '0;
            r_rx_word   <= '0;
            r_rtcal     <= '0;
            r_trcal     <= '0;
        end else begin
            r_din       <= i_demodin;
            r_prev      <= r_din;
            if (i_cnt_enable) r_count <= r_count + 16'd1;
            r_overflow  <= i_cnt_enable && (r_count == 16'hFFFF);
            r_ivl       <= w_rise ? ONE : (r_ivl == SAT ? SAT : r_ivl + ONE);
            r_low       <= r_din ? '0 : (w_fall ? ONE : (r_low == SAT ? SAT : r_low + ONE));
            r_cmd_valid <= 1'b0;
            if (!i_comm_enable) r_state <= S_IDLE;
            else case (r_state)
                S_IDLE: if (w_fall) begin
                    r_state <= S_DELIM;
                    r_bits  <= '0;
                    r_word  <= '0;
                    r_tr    <= '0;
                end
                S_DELIM: begin
                    if (r_low == SAT) r_state <= S_IDLE;
                    else if (w_rise) r_state <= (r_low >= DELIM_MIN) ? S_TARI : S_IDLE;
                end
                S_TARI: begin
                    if (w_sat) r_state <= S_IDLE;
                    else if (w_rise) r_state <= S_RTCAL;
                end
                S_RTCAL: begin
                    if (w_sat) r_state <= S_IDLE;
                    else if (w_rise) begin
                        r_cal   <= r_ivl;
                        r_state <= S_CAL2;
                    end
                end
                S_CAL2, S_DATA: begin
                    if (w_sat || (r_state == S_DATA && r_low >= r_cal)) r_state <= S_IDLE;
                    else if (w_end) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= w_type;
                        r_bit_count <= r_bits;
                        r_rx_word   <= r_word;
                        r_rtcal     <= r_cal;
                        r_trcal     <= r_tr;
                        r_state     <= S_IDLE;
                    end else if (w_rise) begin
                        // an interval longer than RTcal right after RTcal can only be TRcal
                        if (r_state == S_CAL2 && r_ivl > r_cal) r_tr <= r_ivl;
                        else begin
                            if (r_bits < 8'd32) r_word[~r_bits[4:0]] <= w_bit;
                            if (r_bits != 8'hFF) r_bits <= r_bits + 8'd1;
                        end
                        r_state <= S_DATA;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_type  = r_cmd_type;
    assign o_bit_count = r_bit_count;
    assign o_rx_word   = r_rx_word;
    assign o_rtcal     = r_rtcal;
    assign o_trcal     = r_trcal;
    assign o_debug_out = (r_state == S_DATA);
endmodule

// File: tb/tb_rfid_pie_rx_core.sv
// tb_rfid_pie_rx_core: directed bench for the PIE receiver and its cycle counter.
// Frames are built from hand-timed PIE symbols; expected fields are hand-computed constants.
module tb_rfid_pie_rx_core;
    logic        clk = 1'b0, rst = 1'b1, din = 1'b1, ce = 1'b0, cnt_en = 1'b0;
    logic [15:0] count;
    logic        ovf, cmd_valid, debug;
    logic [8:0]  cmd_type;
    logic [7:0]  bit_count;
    logic [31:0] rx_word;
    logic [11:0] rtcal, trcal;
    int n_pass = 0, n_tot = 0, n_valid = 0, n_ovf = 0;

    rfid_pie_rx_core #(.CNT_W(12), .MIN_DELIM(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_demodin(din), .i_comm_enable(ce), .i_cnt_enable(cnt_en),
        .o_count(count), .o_overflow(ovf), .o_cmd_valid(cmd_valid), .o_cmd_type(cmd_type),
        .o_bit_count(bit_count), .o_rx_word(rx_word), .o_rtcal(rtcal), .o_trcal(trcal),
        .o_debug_out(debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tr;
        int          len;
        logic [63:0] pat;
        logic [8:0]  typ;
        logic [31:0] word;
        logic [11:0] trc;
    } vec_t;
    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
        if (cmd_valid) n_valid++;
        if (ovf) n_ovf++;
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h need %0h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, 64'(count), 0);
        chk({tag, "_ovf"}, 64'(ovf), 0);
        chk({tag, "_valid"}, 64'(cmd_valid), 0);
        chk({tag, "_type"}, 64'(cmd_type), 0);
        chk({tag, "_bits"}, 64'(bit_count), 0);
        chk({tag, "_word"}, 64'(rx_word), 0);
        chk({tag, "_rtcal"}, 64'(rtcal), 0);
        chk({tag, "_trcal"}, 64'(trcal), 0);
        chk({tag, "_debug"}, 64'(debug), 0);
    endtask

    // delimiter 24, data-0 24H+24L (48), RTcal 96H+24L (120), optional TRcal 120H+24L (144)
    task automatic send_hdr(input logic tr);
        hold(1, 50); hold(0, 24); hold(1, 24); hold(0, 24); hold(1, 96); hold(0, 24);
        if (tr) begin hold(1, 120); hold(0, 24); end
    endtask

    task automatic send_bit(input logic b);
        hold(1, b ? 48 : 24);
        hold(0, 24);
    endtask

    initial begin
        int v0;
        tbl[0] = '{1'b1, 22, 64'b1000101100111100001101, 9'h004, 32'h8B3C3400, 12'd144};
        tbl[1] = '{1'b0, 9,  64'b100101101,              9'h008, 32'h96800000, 12'd0};
        tbl[2] = '{1'b1, 4,  64'b0010,                   9'h001, 32'h20000000, 12'd144};
        tbl[3] = '{1'b0, 8,  64'hC0,                     9'h020, 32'hC0000000, 12'd0};
        tbl[4] = '{1'b1, 57, 64'hC2A5F00F << 25,         9'h080, 32'hC2A5F00F, 12'd144};
        tbl[5] = '{1'b0, 21, 64'b100010110011110000110,  9'h000, 32'h8B3C3000, 12'd0};
        tbl[6] = '{1'b1, 18, 64'b011010101010101010,     9'h002, 32'h6AAA8000, 12'd144};

        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;
        cnt_en = 1'b1;
        repeat (2000) tick();
        chk("count_2000", 64'(count), 2000);
        chk("ovf_none_2000", 64'(n_ovf), 0);
        repeat (63535) tick();
        chk("count_ffff", 64'(count), 16'hFFFF);
        chk("ovf_before_wrap", 64'(ovf), 0);
        tick();
        chk("count_wrap", 64'(count), 0);
        chk("ovf_pulse", 64'(ovf), 1);
        tick();
        chk("ovf_cleared", 64'(ovf), 0);
        chk("count_after_wrap", 64'(count), 1);
        chk("ovf_once", 64'(n_ovf), 1);
        cnt_en = 1'b0;
        repeat (5) tick();
        chk("count_held", 64'(count), 1);

        ce = 1'b1;
        v0 = n_valid;
        hold(1, 50); hold(0, 4); hold(1, 300);
        chk("short_delim_valid", 64'(n_valid - v0), 0);
        chk("short_delim_debug", 64'(debug), 0);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid;
            send_hdr(tbl[i].tr);
            for (int b = tbl[i].len - 1; b >= 0; b--) send_bit(tbl[i].pat[b]);
            hold(1, 300);
            chk($sformatf("v%0d_pulses", i), 64'(n_valid - v0), 1);
            chk($sformatf("v%0d_type", i), 64'(cmd_type), 64'(tbl[i].typ));
            chk($sformatf("v%0d_bits", i), 64'(bit_count), 64'(tbl[i].len));
            chk($sformatf("v%0d_word", i), 64'(rx_word), 64'(tbl[i].word));
            chk($sformatf("v%0d_rtcal", i), 64'(rtcal), 120);
            chk($sformatf("v%0d_trcal", i), 64'(trcal), 64'(tbl[i].trc));
            chk($sformatf("v%0d_debug", i), 64'(debug), 0);
        end

        v0 = n_valid;
        send_hdr(1'b0);
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        hold(1, 24); hold(0, 130); hold(1, 300);
        chk("long_low_valid", 64'(n_valid - v0), 0);
        chk("long_low_type_held", 64'(cmd_type), 9'h002);

        v0 = n_valid;
        send_hdr(1'b1);
        send_bit(1); send_bit(0); send_bit(0); send_bit(0); send_bit(1);
        chk("data_debug", 64'(debug), 1);
        ce = 1'b0;
        tick();
        chk("disabled_debug", 64'(debug), 0);
        for (int b = 0; b < 17; b++) send_bit(b[0]);
        hold(1, 300);
        ce = 1'b1;
        hold(1, 20);
        chk("disabled_valid", 64'(n_valid - v0), 0);
        chk("disabled_type_held", 64'(cmd_type), 9'h002);
        chk("disabled_bits_held", 64'(bit_count), 18);

        cnt_en = 1'b1;
        send_hdr(1'b1);
        send_bit(1); send_bit(0); send_bit(1);
        chk("pre_reset_debug", 64'(debug), 1);
        rst = 1'b1;
        #1;
        chk_zero("midframe_reset");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
